// File: rtl/prpg_pkg.sv
// Shared types and step functions for the PRPG/MISR logic-BIST sequencer.
package prpg_pkg;

  localparam int PRPG_WIDTH = 3;

  // Taps of x^3+x^2+1 in [3:1] bit order: feedback is q[3]^q[2].
  localparam logic [PRPG_WIDTH:1] TAP_MASK = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  function automatic logic [PRPG_WIDTH:1] lfsr_next(input logic [PRPG_WIDTH:1] q);
    logic fb;
    fb = ^(q & TAP_MASK);
    return {q[PRPG_WIDTH-1:1], fb};
  endfunction

  function automatic logic [PRPG_WIDTH:1] misr_next(input logic [PRPG_WIDTH:1] s,
                                                     input logic [PRPG_WIDTH:1] resp);
    logic fb;
    fb = ^(s & TAP_MASK);
    return {s[PRPG_WIDTH-1:1], fb} ^ resp;
  endfunction

endpackage

// File: rtl/prpg_lfsr.sv
// Fibonacci PRPG register: synchronous load takes priority over the LFSR step.
module prpg_lfsr
  import prpg_pkg::*;
#(
  parameter int WIDTH = PRPG_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH:1]   seed,
  output logic [WIDTH:1]   q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (enable) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/prpg_bist_ctrl.sv
// Logic-BIST sequencer: seeds the PRPG, applies PAT_CNT patterns, compacts responses in a MISR
// and compares against GOLDEN. Optional macro PRPG_LOCKUP_RECOVER_EN escapes an all-zero PRPG.
module prpg_bist_ctrl
  import prpg_pkg::*;
#(
  parameter int               WIDTH   = PRPG_WIDTH,
  parameter int               PAT_CNT = 7,
  parameter logic [WIDTH:1]   SEED    = 3'b001,
  parameter logic [WIDTH:1]   GOLDEN  = 3'b000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH:1]   cut_resp,
  output logic [WIDTH:1]   p_output,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int                CNT_W    = $clog2(PAT_CNT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PAT_CNT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH:1]   prpg_q;
  logic [WIDTH:1]   misr_q;
  logic [WIDTH:1]   last_pat_q;
  logic [CNT_W-1:0] count_q;
  logic             pass_q;
  logic             lfsr_load;
  logic             lfsr_en;
  logic [WIDTH:1]   lfsr_seed;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is only honoured in IDLE and DONE; while busy it is dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SEED;
      S_SEED:    state_d = S_RUN;
      S_RUN:     if (count_q == LAST_CNT) state_d = S_COMPARE;
      S_COMPARE: state_d = S_DONE;
      S_DONE:    if (start) state_d = S_SEED;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_load = (state_q == S_SEED);
    lfsr_en   = (state_q == S_RUN);
    lfsr_seed = SEED;
`ifdef PRPG_LOCKUP_RECOVER_EN
    // An all-zero LFSR never leaves zero; reload a non-zero value for the next pattern.
    if ((state_q == S_RUN) && (prpg_q == '0)) begin
      lfsr_load = 1'b1;
      lfsr_seed = SEED | WIDTH'(1);
    end
`endif
  end

  prpg_lfsr #(
    .WIDTH (WIDTH)
  ) u_lfsr (
    .clk    (clk),
    .clr    (clr),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (lfsr_seed),
    .q      (prpg_q)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      misr_q     <= '0;
      count_q    <= '0;
      pass_q     <= 1'b0;
      last_pat_q <= '0;
    end else begin
      case (state_q)
        S_SEED: begin
          misr_q  <= '0;
          count_q <= '0;
          pass_q  <= 1'b0;
        end
        S_RUN: begin
          misr_q     <= misr_next(misr_q, cut_resp);
          count_q    <= count_q + 1'b1;
          last_pat_q <= prpg_q;
        end
        S_COMPARE: begin
          pass_q <= (misr_q == GOLDEN);
        end
        default: begin
        end
      endcase
    end
  end

  // Outside RUN the CUT keeps seeing the last applied pattern.
  assign p_output  = (state_q == S_RUN) ? prpg_q : last_pat_q;
  assign pat_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_SEED) || (state_q == S_RUN) || (state_q == S_COMPARE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;

endmodule

// File: tb/tb_prpg_bist_ctrl.sv
// Self-checking bench for prpg_bist_ctrl: four instances cover the default, fail, signature and zero-seed cases.
module tb_prpg_bist_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:1] resp_zero = 3'b000;
  logic [3:1] resp_one  = 3'b001;

  logic [3:1] p_main, p_fail, p_sig, p_zero;
  logic       v_main, v_fail, v_sig, v_zero;
  logic       b_main, b_fail, b_sig, b_zero;
  logic       d_main, d_fail, d_sig, d_zero;
  logic       pa_main, pa_fail, pa_sig, pa_zero;

  int checks   = 0;
  int failures = 0;

  logic [3:1] main_seq [7];
  logic [3:1] zero_seq [7];
  logic [3:1] sig_trace [3];
  logic [3:1] exp_main_q [$];
  logic [3:1] exp_zero_q [$];
  logic [3:1] exp_sig_q  [$];

  always #5 clk = ~clk;

  prpg_bist_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .cut_resp(resp_zero),
    .p_output(p_main), .pat_valid(v_main), .busy(b_main), .done(d_main), .pass(pa_main)
  );

  prpg_bist_ctrl #(.GOLDEN(3'b001)) dut_fail (
    .clk(clk), .clr(clr), .start(start), .cut_resp(resp_zero),
    .p_output(p_fail), .pat_valid(v_fail), .busy(b_fail), .done(d_fail), .pass(pa_fail)
  );

  prpg_bist_ctrl #(.PAT_CNT(3), .GOLDEN(3'b110)) dut_sig (
    .clk(clk), .clr(clr), .start(start), .cut_resp(resp_one),
    .p_output(p_sig), .pat_valid(v_sig), .busy(b_sig), .done(d_sig), .pass(pa_sig)
  );

  prpg_bist_ctrl #(.SEED(3'b000)) dut_zero (
    .clk(clk), .clr(clr), .start(start), .cut_resp(resp_zero),
    .p_output(p_zero), .pat_valid(v_zero), .busy(b_zero), .done(d_zero), .pass(pa_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raises start at a falling edge and queues what every instance should produce for that run.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    exp_main_q.delete();
    exp_zero_q.delete();
    exp_sig_q.delete();
    for (int i = 0; i < 7; i++) begin
      exp_main_q.push_back(main_seq[i]);
      exp_zero_q.push_back(zero_seq[i]);
    end
    for (int i = 0; i < 3; i++) exp_sig_q.push_back(sig_trace[i]);
  endtask

  task automatic runAndCheck(input int ign_a, input int ign_b, input logic [3:1] prev_last);
    int cyc;
    int nvalid;
    int ndone;
    bit seen_done;
    cyc = 0;
    nvalid = 0;
    ndone = 0;
    seen_done = 1'b0;
    applyStimulus();
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checkOutput("busy_in_seed", b_main, 1'b1);
        checkOutput("p_output_hold_seed", p_main, prev_last);
      end
      if (v_main) begin
        nvalid++;
        if (exp_main_q.size() > 0) checkOutput("pattern", p_main, exp_main_q.pop_front());
      end
      if (v_zero && exp_zero_q.size() > 0) checkOutput("zero_seed_pattern", p_zero, exp_zero_q.pop_front());
      if (v_sig && exp_sig_q.size() > 0) checkOutput("misr_trace", dut_sig.misr_q, exp_sig_q.pop_front());
      if (d_main) seen_done = 1'b1;
      start = (cyc == ign_a || cyc == ign_b) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    checkOutput("done_latency", cyc, 10);
    checkOutput("pat_valid_count", nvalid, 7);
    checkOutput("pattern_queue_drained", exp_main_q.size(), 0);
    checkOutput("pass_default", pa_main, 1'b1);
    checkOutput("fail_done", d_fail, 1'b1);
    checkOutput("fail_pass", pa_fail, 1'b0);
    checkOutput("sig_done", d_sig, 1'b1);
    checkOutput("sig_pass", pa_sig, 1'b1);
    checkOutput("sig_final_misr", dut_sig.misr_q, 3'b110);
    checkOutput("zero_queue_drained", exp_zero_q.size(), 0);
    // DONE must hold with no hidden restart from any ignored start pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d_main) ndone++;
      if (v_main) nvalid++;
    end
    checkOutput("done_held", ndone, 3);
    checkOutput("no_restart", nvalid, 7);
    checkOutput("p_output_hold_done", p_main, 3'b100);
    checkOutput("pass_held", pa_main, 1'b1);
  endtask

  initial begin
    main_seq  = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
`ifdef PRPG_LOCKUP_RECOVER_EN
    zero_seq  = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110};
`else
    zero_seq  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
    sig_trace = '{3'b000, 3'b001, 3'b011};

    clr   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_p_output", p_main, 3'b000);
    checkOutput("reset_pat_valid", v_main, 1'b0);
    checkOutput("reset_busy", b_main, 1'b0);
    checkOutput("reset_done", d_main, 1'b0);
    checkOutput("reset_pass", pa_main, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("idle_no_start", b_main, 1'b0);

    $display("[TB] run 1: sequence, fail path, signature, zero seed");
    runAndCheck(0, 0, 3'b000);

    $display("[TB] run 2: rerun from DONE with start pulses during RUN");
    runAndCheck(3, 5, 3'b100);

    $display("[TB] run 3: abort during the 4th pattern");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_4th_pattern", p_main, 3'b011);
    clr = 1'b1;
    #1;
    checkOutput("abort_busy", b_main, 1'b0);
    checkOutput("abort_pat_valid", v_main, 1'b0);
    checkOutput("abort_p_output", p_main, 3'b000);
    checkOutput("abort_done", d_main, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("abort_stays_idle", b_main, 1'b0);

    $display("[TB] run 4: clean run after abort");
    runAndCheck(0, 0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prpg_bist_ctrl.md
Name: prpg_bist_ctrl

Overview:
- Logic-BIST sequencer built around the 3-bit PRPG LFSR datapath.
- On `start`, it seeds an internal PRPG and drives PAT_CNT pseudo-random patterns to the circuit-under-test (CUT).
- It compacts the CUT responses in a MISR, then compares the final signature against a golden value and reports pass/fail.
- Sits between the test-access logic (start/done) and the CUT inputs/outputs.

Parameters:
- WIDTH, 3, PRPG/MISR width; bit indices run [WIDTH:1].
- PAT_CNT, 7, number of patterns applied per run (1..2^WIDTH-1).
- SEED, 3'b001, PRPG load value on entering SEED state.
- GOLDEN, 3'b000, expected final MISR signature.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset; asynchronous, active-high.
- start  input  1  single-cycle run request; sampled in IDLE and DONE only.
- cut_resp  input  WIDTH  CUT response to the current p_output; combinational path, valid in the same cycle.
- p_output  output  WIDTH  current PRPG pattern to the CUT.
- pat_valid  output  1  high while p_output is a live test pattern (RUN state).
- busy  output  1  high in SEED, RUN and COMPARE.
- done  output  1  high in DONE.
- pass  output  1  signature matched GOLDEN; meaningful only when done=1.

Behaviour:
- Reset (clr=1, async): state=IDLE, PRPG=0, MISR=0, count=0, p_output=0, pat_valid=0, busy=0, done=0, pass=0.
- PRPG step (polynomial x^3+x^2+1, Fibonacci): fb=q[3]^q[2]; q<={q[2],q[1],fb}.
  - Sequence from 001: 001,010,101,011,111,110,100,001 (period 7).
- MISR step: s<={s[2],s[1],s[3]^s[2]} ^ cut_resp.
- FSM:
  - IDLE: start=1 -> SEED.
  - SEED (1 cycle): PRPG<=SEED, MISR<=0, count<=0 -> RUN.
  - RUN:
    - Each cycle: pat_valid=1, p_output=PRPG; MISR absorbs cut_resp; PRPG steps; count<=count+1.
    - When count==PAT_CNT-1 -> COMPARE.
    - Exactly PAT_CNT patterns are applied.
  - COMPARE (1 cycle): pass<=(MISR==GOLDEN) -> DONE.
  - DONE: done=1; pass, p_output and MISR hold; start=1 -> SEED (rerun). There is no path back to IDLE except clr.
- Latency: start at cycle N -> first pattern visible at N+2 -> done at N+2+PAT_CNT+1.
- start while busy is ignored; it is not queued.
- p_output holds its last value outside RUN.
- clr asserted mid-run aborts immediately to reset values; no partial result is reported.
- count width is clog2(PAT_CNT+1); no wrap within a run.
- PRPG wraps naturally; if PAT_CNT > period, patterns repeat.

Optional Feature:
- Macro: PRPG_LOCKUP_RECOVER_EN.
- Defined: in RUN, if PRPG==0 (only possible with SEED=0), the next PRPG value is SEED|1 instead of the LFSR step. Lockup is escaped in one cycle, and that cycle still counts as a pattern.
- Undefined: an all-zero PRPG stays zero for the whole run. p_output=0 for all patterns.

Decomposition:
- Shared package prpg_pkg:
  - state enum (IDLE, SEED, RUN, COMPARE, DONE);
  - WIDTH default;
  - tap-mask constant 3'b110;
  - lfsr_next and misr_next functions.
- One natural sub-module: prpg_lfsr (load, enable, seed, q). The MISR and FSM stay in the top.

Test Plan:
1. Sequence and timing.
   - Stimulus: clr pulse, then start, with defaults (SEED=001, PAT_CNT=7, cut_resp=0).
   - Required: p_output during pat_valid = 001,010,101,011,111,110,100; done 10 cycles after start; pass=1.
2. Fail path.
   - Stimulus: same run with GOLDEN=3'b001.
   - Required: done=1, pass=0.
3. Signature arithmetic.
   - Stimulus: PAT_CNT=3, cut_resp held at 3'b001, GOLDEN=3'b110.
   - Required: MISR goes 001, 011, 110; pass=1.
4. Ignored start.
   - Stimulus: start pulses during RUN.
   - Required: no restart; exactly 7 pat_valid cycles; a single done.
5. Abort.
   - Stimulus: clr asserted during the 4th pattern.
   - Required: immediately busy=0, pat_valid=0, p_output=000, done=0; a following start gives a clean full run with pass=1.
6. Lockup recovery, with PRPG_LOCKUP_RECOVER_EN defined.
   - Stimulus: SEED=000.
   - Required: patterns 000,001,010,101,...
   - Without the macro: all 7 patterns are 000.
